status_unit: RTL and testbench

STATUS_UNIT -- requirements
Module: status_unit

---
 rtl/status_unit.sv | 83 ++++++++
 tb/tb_status_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_unit.sv
// rtl/status_unit.sv - condition-flag pipeline with hazard stall and stall counter; FLAG_FWD_EN selects flag forwarding
module status_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        idValid,
  input  logic        idSetFlags,
  input  logic        idUsesCond,
  input  logic [3:0]  exStatusIn,
  output logic [3:0]  statusOut,
  output logic        condStall,
  output logic [15:0] stallCount
);

  logic        r_ex_pend;
  logic        r_mem_pend;
  logic [3:0]  r_mem_flags;
  logic [3:0]  r_sr;
  logic [15:0] r_stall_count;

  logic        w_cond_stall;
  logic        w_accept;
  logic [3:0]  w_status;

`ifdef FLAG_FWD_EN
  // Forward the youngest in-flight flag producer; conditions never have to wait.
  always_comb begin
    w_status     = r_sr;
    w_cond_stall = 1'b0;
    if (r_ex_pend) begin
      w_status = exStatusIn;
    end else if (r_mem_pend) begin
      w_status = r_mem_flags;
    end
  end

  logic w_unused_cond;
  assign w_unused_cond = idUsesCond;
`else
  // Conditions read the architectural SR and hold in ID while any flag write is in flight.
  always_comb begin
    w_status     = r_sr;
    w_cond_stall = idValid & idUsesCond & (r_ex_pend | r_mem_pend) & ~flush & ~freeze;
  end
`endif

  // A setter leaves ID only when it is not stalled and not killed by a taken branch.
  assign w_accept = idValid & idSetFlags & ~w_cond_stall & ~flush;

  // Flag pipeline ID->EX->MEM->SR; freeze holds everything except the flush kill of EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_pend     <= 1'b0;
      r_mem_pend    <= 1'b0;
      r_mem_flags   <= 4'b0000;
      r_sr          <= 4'b0000;
      r_stall_count <= 16'h0000;
    end else if (freeze) begin
      if (flush) begin
        r_ex_pend <= 1'b0;
      end
    end else begin
      r_ex_pend  <= w_accept;
      r_mem_pend <= r_ex_pend & ~flush;
      if (r_ex_pend && !flush) begin
        r_mem_flags <= exStatusIn;
      end
      // A MEM-stage write is already committed, so flush does not cancel it.
      if (r_mem_pend) begin
        r_sr <= r_mem_flags;
      end
      if (w_cond_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'h0001;
      end
    end
  end

  assign statusOut  = w_status;
  assign condStall  = w_cond_stall;
  assign stallCount = r_stall_count;

endmodule

// File: tb/tb_status_unit.sv
// tb/tb_status_unit.sv - self-checking bench for status_unit with an in-flight-write queue model
module tb_status_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        idValid;
  logic        idSetFlags;
  logic        idUsesCond;
  logic [3:0]  exStatusIn;
  logic [3:0]  statusOut;
  logic        condStall;
  logic [15:0] stallCount;

  int n_run  = 0;
  int n_fail = 0;

  // Each accepted setter is one record: the logical cycle it left ID and the flags it will write.
  typedef struct {
    int         issue;
    logic [3:0] flags;
  } ent_t;

  ent_t        q[$];
  int          t_now   = 0;
  logic [3:0]  m_sr    = 4'b0000;
  logic [15:0] m_cnt   = 16'h0000;
  bit          started = 1'b0;
  bit          pending = 1'b0;

  always #5 clk = ~clk;

  status_unit dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .idValid    (idValid),
    .idSetFlags (idSetFlags),
    .idUsesCond (idUsesCond),
    .exStatusIn (exStatusIn),
    .statusOut  (statusOut),
    .condStall  (condStall),
    .stallCount (stallCount)
  );

  function automatic bit m_stall();
`ifdef FLAG_FWD_EN
    return 1'b0;
`else
    return idValid && idUsesCond && (q.size() != 0) && !flush && !freeze;
`endif
  endfunction

  function automatic logic [3:0] m_status();
    logic [3:0] v;
    v = m_sr;
`ifdef FLAG_FWD_EN
    foreach (q[i]) if (q[i].issue == t_now - 2) v = q[i].flags;
    foreach (q[i]) if (q[i].issue == t_now - 1) v = exStatusIn;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs of the cycle that is ending.
  task automatic model_advance();
    ent_t nq[$];
    bit   st;
    st = m_stall();
    if (rst) begin
      q.delete();
      m_sr    = 4'b0000;
      m_cnt   = 16'h0000;
      started = 1'b1;
    end else if (freeze) begin
      foreach (q[i]) if (!(flush && q[i].issue == t_now - 1)) nq.push_back(q[i]);
      q = nq;
    end else begin
      foreach (q[i]) begin
        if (q[i].issue == t_now - 2) begin
          m_sr = q[i].flags;
        end else if (!flush) begin
          ent_t e;
          e       = q[i];
          e.flags = exStatusIn;
          nq.push_back(e);
        end
      end
      if (idValid && idSetFlags && !st && !flush) nq.push_back('{t_now, 4'b0000});
      if (st && m_cnt != 16'hFFFF) m_cnt++;
      q = nq;
      t_now++;
    end
  endtask

  // One cycle: finish the previous edge, drive new inputs, compare everything at the falling edge.
  task automatic drive(input bit r, input bit fz, input bit fl, input bit v,
                       input bit s, input bit c, input logic [3:0] ex);
    if (pending) begin
      model_advance();
      @(posedge clk);
      #1;
    end
    rst        = r;
    freeze     = fz;
    flush      = fl;
    idValid    = v;
    idSetFlags = s;
    idUsesCond = c;
    exStatusIn = ex;
    @(negedge clk);
    if (started) begin
      chk("cyc statusOut", {12'h000, statusOut}, {12'h000, m_status()});
      chk("cyc condStall", {15'h0000, condStall}, {15'h0000, m_stall()});
      chk("cyc stallCount", stallCount, m_cnt);
    end
    pending = 1'b1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 4'b0000);
    drive(1, 0, 0, 0, 0, 0, 4'b0000);
  endtask

  initial begin
    do_reset();
    idle();
    chk("reset statusOut", {12'h000, statusOut}, 16'h0000);
    chk("reset condStall", {15'h0000, condStall}, 16'h0000);
    chk("reset stallCount", stallCount, 16'h0000);

    // Setter directly followed by a conditional consumer.
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 0, 0, 1, 0, 1, 4'b0100);
`ifdef FLAG_FWD_EN
    chk("fwd first stall", {15'h0000, condStall}, 16'h0000);
    chk("fwd first status", {12'h000, statusOut}, 16'h0004);
`else
    chk("dep stall 1", {15'h0000, condStall}, 16'h0001);
`endif
    drive(0, 0, 0, 1, 0, 1, 4'b0000);
`ifndef FLAG_FWD_EN
    chk("dep stall 2", {15'h0000, condStall}, 16'h0001);
`endif
    drive(0, 0, 0, 1, 0, 1, 4'b0000);
`ifdef FLAG_FWD_EN
    chk("fwd count", stallCount, 16'h0000);
`else
    chk("dep released", {15'h0000, condStall}, 16'h0000);
    chk("dep count", stallCount, 16'h0002);
`endif
    chk("dep status", {12'h000, statusOut}, 16'h0004);
    idle();

    // Flush kills the EX setter; a MEM setter still writes.
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 0, 1, 0, 0, 0, 4'b1000);
    drive(0, 0, 0, 1, 0, 1, 4'b0000);
    chk("flush no stall", {15'h0000, condStall}, 16'h0000);
    idle();
    chk("flush sr kept", {12'h000, statusOut}, 16'h0000);
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 0, 0, 0, 0, 0, 4'b0010);
    drive(0, 0, 1, 0, 0, 0, 4'b0000);
    idle();
    chk("flush mem writes", {12'h000, statusOut}, 16'h0002);

    // Flush during freeze still clears the EX entry.
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 1, 1, 0, 0, 0, 4'b1111);
    drive(0, 0, 0, 1, 0, 1, 4'b0000);
    chk("frzflush no stall", {15'h0000, condStall}, 16'h0000);
    idle();
    chk("frzflush sr kept", {12'h000, statusOut}, 16'h0002);

    // Freeze plus flush holds a MEM write until the first unfrozen edge.
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 0, 0, 0, 0, 0, 4'b0101);
    drive(0, 1, 1, 0, 0, 0, 4'b0000);
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    idle();
    chk("frzflush mem write", {12'h000, statusOut}, 16'h0005);

    // Freeze for three cycles in the middle of a hazard.
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 0, 0, 1, 0, 1, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 1, 4'b0000);
`ifndef FLAG_FWD_EN
      chk("freeze count held", stallCount, 16'h0001);
      chk("freeze sr held", {12'h000, statusOut}, 16'h0000);
`endif
    end
    drive(0, 0, 0, 1, 0, 1, 4'b0000);
`ifndef FLAG_FWD_EN
    chk("freeze resume stall", {15'h0000, condStall}, 16'h0001);
`endif
    drive(0, 0, 0, 1, 0, 1, 4'b0000);
`ifndef FLAG_FWD_EN
    chk("freeze final count", stallCount, 16'h0002);
`endif
    chk("freeze final status", {12'h000, statusOut}, 16'h0006);

    // Back-to-back setters write in program order.
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 0, 0, 1, 1, 0, 4'b0011);
    drive(0, 0, 0, 0, 0, 0, 4'b1001);
    idle();
`ifndef FLAG_FWD_EN
    chk("b2b first", {12'h000, statusOut}, 16'h0003);
`endif
    idle();
    chk("b2b last wins", {12'h000, statusOut}, 16'h0009);

    // Reset in the middle of a stall drops the in-flight write.
    drive(0, 0, 0, 1, 1, 0, 4'b0000);
    drive(0, 0, 0, 1, 0, 1, 4'b1111);
    drive(1, 0, 0, 1, 0, 1, 4'b0000);
    drive(0, 0, 0, 1, 0, 1, 4'b0000);
    chk("rst stall cleared", {15'h0000, condStall}, 16'h0000);
    chk("rst count cleared", stallCount, 16'h0000);
    idle();
    idle();
    chk("rst write dropped", {12'h000, statusOut}, 16'h0000);

    // Saturation from a preloaded count.
    do_reset();
    drive(0, 0, 0, 1, 1, 1, 4'b0000);
    force dut.r_stall_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_count;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 1, 1, 4'b0000);
    idle();
`ifdef FLAG_FWD_EN
    chk("sat count", stallCount, 16'hFFFE);
`else
    chk("sat count", stallCount, 16'hFFFF);
`endif
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
